// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and constants for the 7-segment scanner
package seg_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_GUARD = 2'd1,
        ST_DRIVE = 2'd2
    } seg_state_e;

endpackage

// File: rtl/seg_tick_gen.sv
// rtl/seg_tick_gen.sv - digit-slot prescaler, counts 0..PRESCALE-1 and flags the last cycle
module seg_tick_gen #(
    parameter int PRESCALE = 50000,
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          tick
);

    logic [CW-1:0] r_cnt;
    logic          w_tick;

    assign w_tick = (r_cnt == CW'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (reset || clr || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt  = r_cnt;
    assign tick = w_tick;

endmodule

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - double-buffered, time-multiplexed scanner for a common-anode 7-segment display
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int GUARD    = 4,
    parameter int LZ_EN    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_data,
    output logic [3:0]            bcd,
    output logic [DIGITS-1:0]     dig_n,
    output logic                  frame_done
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);
    localparam logic [CW-1:0] GUARD_END = CW'(GUARD - 1);

    seg_state_e            r_state;
    seg_state_e            w_state_nxt;
    logic [IW-1:0]         r_idx;
    logic [CW-1:0]         w_cnt;
    logic                  w_tick;
    logic                  w_clr;
    logic                  w_boundary;
    logic                  w_accept;
    logic [4*DIGITS-1:0]   r_pending;
    logic [4*DIGITS-1:0]   r_display;
    logic                  r_pend_vld;
    logic [DIGITS-1:0]     w_nz_from;
    logic                  w_blank;
    logic [3:0]            w_bcd_nxt;
    logic [DIGITS-1:0]     w_dig_n_nxt;
    logic [3:0]            r_bcd;
    logic [DIGITS-1:0]     r_dig_n;
    logic                  r_frame_done;

    assign w_clr = ~enable | (r_state == ST_OFF);

    seg_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr),
        .cnt   (w_cnt),
        .tick  (w_tick)
    );

    assign w_boundary = enable & (r_state == ST_DRIVE) & w_tick & (r_idx == LAST_IDX);
    assign in_ready   = ~r_pend_vld & ~reset;
    assign w_accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = ST_OFF;
        end else begin
            case (r_state)
                ST_OFF:   w_state_nxt = ST_GUARD;
                ST_GUARD: if (w_cnt == GUARD_END) w_state_nxt = ST_DRIVE;
                ST_DRIVE: if (w_tick) w_state_nxt = ST_GUARD;
                default:  w_state_nxt = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            r_idx <= '0;
        end else if (r_state == ST_DRIVE && w_tick) begin
            r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        end
    end

    // Display only changes at a frame boundary so a frame never mixes two values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending  <= '0;
            r_display  <= '0;
            r_pend_vld <= 1'b0;
        end else if (w_boundary && r_pend_vld) begin
            r_display  <= r_pending;
            r_pend_vld <= 1'b0;
        end else if (w_accept) begin
            r_pending  <= in_data;
            r_pend_vld <= 1'b1;
        end
    end

    // w_nz_from[i]: some nibble at position i or above is nonzero.
    always_comb begin
        logic v_acc;
        v_acc     = 1'b0;
        w_nz_from = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            v_acc        = v_acc | (r_display[4*i +: 4] != 4'h0);
            w_nz_from[i] = v_acc;
        end
    end

    always_comb begin
        w_blank     = (LZ_EN != 0) && (r_idx != '0) && !w_nz_from[r_idx];
        w_dig_n_nxt = '1;
        w_bcd_nxt   = BLANK_CODE;
        if (enable && r_state == ST_DRIVE && !w_blank) begin
            w_dig_n_nxt = ~(DIGITS'(1) << r_idx);
            w_bcd_nxt   = r_display[4*r_idx +: 4];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dig_n      <= '1;
            r_bcd        <= BLANK_CODE;
            r_frame_done <= 1'b0;
        end else begin
            r_dig_n      <= w_dig_n_nxt;
            r_bcd        <= w_bcd_nxt;
            r_frame_done <= w_boundary;
        end
    end

    assign dig_n      = r_dig_n;
    assign bcd        = r_bcd;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - self-checking bench for seg_scan_mux (DIGITS=4, PRESCALE=8, GUARD=2)
module tb_seg_scan_mux;

    localparam int D = 4;
    localparam int P = 8;
    localparam int G = 2;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        in_valid;
    logic [15:0] in_data;
    logic        rdy0, rdy1;
    logic [3:0]  bcd0, bcd1;
    logic [3:0]  dign0, dign1;
    logic        fd0, fd1;

    int n_chk = 0;
    int n_err = 0;

    seg_scan_mux #(.DIGITS(D), .PRESCALE(P), .GUARD(G), .LZ_EN(0)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .bcd(bcd0), .dig_n(dign0), .frame_done(fd0)
    );

    seg_scan_mux #(.DIGITS(D), .PRESCALE(P), .GUARD(G), .LZ_EN(1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .bcd(bcd1), .dig_n(dign1), .frame_done(fd1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: m_t is the position within the frame (slot*P + offset), -1 when dark/off.
    int          m_t;
    int          m_pos;
    int          m_slot;
    bit          m_live;
    bit          m_on = 0;
    bit          m_pv;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    logic [3:0]  e_dign [2];
    logic [3:0]  e_bcd  [2];
    bit          e_fd;

    always @(posedge clk) begin
        if (reset) begin
            m_on   = 1;
            m_t    = -1;
            m_disp = '0;
            m_pend = '0;
            m_pv   = 0;
            e_fd   = 0;
            for (int d = 0; d < 2; d++) begin
                e_dign[d] = 4'hF;
                e_bcd[d]  = 4'hF;
            end
        end else if (m_on) begin
            m_live = enable && (m_t >= 0);
            m_pos  = m_live ? m_t % P : 0;
            m_slot = m_live ? (m_t / P) % D : 0;
            for (int d = 0; d < 2; d++) begin
                if (m_live && m_pos >= G &&
                    !(d == 1 && m_slot != 0 && (m_disp >> (4 * m_slot)) == 16'h0)) begin
                    e_dign[d] = ~(4'b0001 << m_slot);
                    e_bcd[d]  = m_disp[4*m_slot +: 4];
                end else begin
                    e_dign[d] = 4'hF;
                    e_bcd[d]  = 4'hF;
                end
            end
            e_fd = m_live && m_pos == P - 1 && m_slot == D - 1;
            if (e_fd && m_pv) begin
                m_disp = m_pend;
                m_pv   = 0;
            end else if (in_valid && !m_pv) begin
                m_pend = in_data;
                m_pv   = 1;
            end
            m_t = !enable ? -1 : (m_t < 0 ? 0 : (m_t + 1) % (D * P));
        end
    end

    always @(negedge clk) begin
        #1;
        if (m_on) begin
            chk("model_rdy0", {31'b0, rdy0}, {31'b0, !m_pv && !reset});
            chk("model_rdy1", {31'b0, rdy1}, {31'b0, !m_pv && !reset});
            chk("model_fd0", {31'b0, fd0}, {31'b0, e_fd});
            chk("model_fd1", {31'b0, fd1}, {31'b0, e_fd});
            chk("model_dign0", {28'b0, dign0}, {28'b0, e_dign[0]});
            chk("model_bcd0", {28'b0, bcd0}, {28'b0, e_bcd[0]});
            chk("model_dign1", {28'b0, dign1}, {28'b0, e_dign[1]});
            chk("model_bcd1", {28'b0, bcd1}, {28'b0, e_bcd[1]});
        end
    end

    task automatic wait_fd();
        bit got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (fd0 === 1'b1) got = 1;
        end
        chk("wait_frame_done", {31'b0, got}, 32'd1);
    endtask

    task automatic send(input logic [15:0] d);
        bit done = 0;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (rdy0 === 1'b1) done = 1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("send_accepted", {31'b0, done}, 32'd1);
    endtask

    // dn/bc hold the expected dig_n/bcd per slot, slot 0 in the low nibble.
    task automatic check_frame(input int d, input logic [15:0] dn, input logic [15:0] bc, input string tag);
        logic [3:0] adn, abc;
        wait_fd();
        @(negedge clk);
        adn = d ? dign1 : dign0;
        chk($sformatf("%s_guard_dign", tag), {28'b0, adn}, 32'hF);
        repeat (2) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            if (s > 0) repeat (8) @(negedge clk);
            adn = d ? dign1 : dign0;
            abc = d ? bcd1 : bcd0;
            chk($sformatf("%s_dign_s%0d", tag, s), {28'b0, adn}, {28'b0, dn[4*s +: 4]});
            chk($sformatf("%s_bcd_s%0d", tag, s), {28'b0, abc}, {28'b0, bc[4*s +: 4]});
        end
    endtask

    initial begin
        bit ok;
        bit got;
        int lit;
        reset    = 1'b1;
        enable   = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;

        repeat (3) @(negedge clk);
        chk("t1_rdy_in_reset", {31'b0, rdy0}, 32'd0);
        chk("t1_dign_in_reset", {28'b0, dign0}, 32'hF);
        chk("t1_bcd_in_reset", {28'b0, bcd0}, 32'hF);
        chk("t1_dign1_in_reset", {28'b0, dign1}, 32'hF);
        reset = 1'b0;
        @(negedge clk);
        chk("t1_rdy_after", {31'b0, rdy0}, 32'd1);

        send(16'h1234);
        wait_fd();
        check_frame(0, 16'h7BDE, 16'h1234, "t2");

        send(16'h0070);
        wait_fd();
        check_frame(1, 16'hFFDE, 16'hFF70, "t3a");
        send(16'h0000);
        wait_fd();
        check_frame(1, 16'hFFFE, 16'hFFF0, "t3b");

        send(16'h1111);
        chk("t4_rdy_low", {31'b0, rdy0}, 32'd0);
        send(16'h2222);
        ok = 1; lit = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (dign0 !== 4'hF) begin
                lit++;
                if (bcd0 !== 4'h1) ok = 0;
            end
            if (fd0 === 1'b1) got = 1;
        end
        chk("t4_f1_fd", {31'b0, got}, 32'd1);
        chk("t4_f1_bcd", {31'b0, ok}, 32'd1);
        chk("t4_f1_lit", lit, 32'd24);
        ok = 1; lit = 0;
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            if (dign0 !== 4'hF) begin
                lit++;
                if (bcd0 !== 4'h2) ok = 0;
            end
        end
        chk("t4_f2_bcd", {31'b0, ok}, 32'd1);
        chk("t4_f2_lit", lit, 32'd23);

        wait_fd();
        repeat (20) @(negedge clk);
        chk("t5_dign_d2", {28'b0, dign0}, 32'hB);
        enable = 1'b0;
        @(negedge clk);
        chk("t5_dark", {28'b0, dign0}, 32'hF);
        repeat (3) @(negedge clk);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_guard_dark", {28'b0, dign0}, 32'hF);
        @(negedge clk);
        chk("t5_digit0", {28'b0, dign0}, 32'hE);
        chk("t5_digit0_bcd", {28'b0, bcd0}, 32'h2);

        wait_fd();
        repeat (5) @(negedge clk);
        send(16'h9999);
        chk("t6_pending", {31'b0, rdy0}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_rdy_in_reset", {31'b0, rdy0}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_rdy_after", {31'b0, rdy0}, 32'd1);
        check_frame(1, 16'hFFFE, 16'hFFF0, "t6_lz");
        check_frame(0, 16'h7BDE, 16'h0000, "t6_nolz");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
